// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one registered 8-bit ALU among N requesters.
// Divide-by-zero is intercepted: the ALU sees 0+0 and the response carries 16'hFFFF with rsp_err set.
module alu_share_ctrl #(
    parameter int N       = 4,
    parameter int ALU_LAT = 1,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [N*8-1:0]  req_a,
    input  logic [N*8-1:0]  req_b,
    input  logic [N*2-1:0]  req_op,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [1:0]      alu_op,
    input  logic [15:0]     alu_q,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [15:0]     rsp_data,
    output logic [IW-1:0]   rsp_id,
    output logic            rsp_err,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_reg;
    logic [IW-1:0] rr_ptr_reg;
    logic [IW-1:0] id_reg;
    logic [2:0]    cnt_reg;
    logic          dz_reg;
    logic [7:0]    alu_a_reg;
    logic [7:0]    alu_b_reg;
    logic [1:0]    alu_op_reg;
    logic [15:0]   rsp_data_reg;
    logic [IW-1:0] rsp_id_reg;
    logic          rsp_err_reg;

    logic [7:0]    a_arr  [N];
    logic [7:0]    b_arr  [N];
    logic [1:0]    op_arr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign a_arr[gi]  = req_a[8*gi +: 8];
            assign b_arr[gi]  = req_b[8*gi +: 8];
            assign op_arr[gi] = req_op[2*gi +: 2];
        end
    endgenerate

    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] cand;

    // First valid requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(rr_ptr_reg) + k) % N);
            if (!grant_valid && req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_reg == IDLE && grant_valid)
            req_ready[grant_idx] = 1'b1;
    end

    logic sel_dz;
    assign sel_dz = (op_arr[grant_idx] == 2'b11) && (b_arr[grant_idx] == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            id_reg       <= '0;
            cnt_reg      <= '0;
            dz_reg       <= 1'b0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= '0;
            rsp_data_reg <= '0;
            rsp_id_reg   <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        alu_a_reg  <= sel_dz ? 8'd0 : a_arr[grant_idx];
                        alu_b_reg  <= sel_dz ? 8'd0 : b_arr[grant_idx];
                        alu_op_reg <= sel_dz ? 2'b00 : op_arr[grant_idx];
                        dz_reg     <= sel_dz;
                        id_reg     <= grant_idx;
                        cnt_reg    <= 3'(ALU_LAT);
                        rr_ptr_reg <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable for ALU_LAT cycles once the counter hits zero.
                    if (cnt_reg == 3'd0) begin
                        rsp_data_reg <= dz_reg ? 16'hFFFF : alu_q;
                        rsp_id_reg   <= id_reg;
                        rsp_err_reg  <= dz_reg;
                        state_reg    <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op    = alu_op_reg;
    assign rsp_valid = (state_reg == RESP);
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_err   = rsp_err_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed scenarios plus random traffic,
// with a cycle-level reference model of grant order, latency and results.
module tb_alu_share_ctrl;
    localparam int N       = 4;
    localparam int ALU_LAT = 1;
    localparam int IW      = $clog2(N);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_ready;
    logic [N*8-1:0] req_a, req_b;
    logic [N*2-1:0] req_op;
    logic [7:0]     alu_a, alu_b;
    logic [1:0]     alu_op;
    logic [15:0]    alu_q;
    logic           rsp_valid, rsp_ready;
    logic [15:0]    rsp_data;
    logic [IW-1:0]  rsp_id;
    logic           rsp_err, busy;

    logic [7:0] ta [N];
    logic [7:0] tbv [N];
    logic [1:0] top_ [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign req_a[8*gi +: 8]  = ta[gi];
            assign req_b[8*gi +: 8]  = tbv[gi];
            assign req_op[2*gi +: 2] = top_[gi];
        end
    endgenerate

    alu_share_ctrl #(.N(N), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_q(alu_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    // External ALU: ALU_LAT register stages behind the operand bus.
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return {8'd0, a} + {8'd0, b};
            2'b01:   return {8'd0, a} - {8'd0, b};
            2'b10:   return {8'd0, a} * {8'd0, b};
            default: return (b == 8'd0) ? 16'd0 : {8'd0, a} / {8'd0, b};
        endcase
    endfunction

    logic [16*ALU_LAT-1:0] alu_sr;
    always @(posedge clk) alu_sr <= (16*ALU_LAT)'({alu_sr, alu_f(alu_a, alu_b, alu_op)});
    assign alu_q = alu_sr[16*ALU_LAT-1 -: 16];

    typedef struct {
        int         id;
        logic [15:0] data;
        logic       err;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0, n_total = 0;
    int   cyc = 0, acc_cyc = 0, model_ptr = 0;
    bit   inflight = 1'b0, prev_reset = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL timeout %s: got no event, expected one within the cycle budget", name);
    endtask

    // Reference arithmetic on plain integers.
    function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                                   output logic [15:0] d, output logic e);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        e  = 1'b0;
        case (op)
            2'b00: r = ia + ib;
            2'b01: r = ia - ib;
            2'b10: r = ia * ib;
            default: begin
                if (ib == 0) begin r = 32'hFFFF; e = 1'b1; end
                else r = ia / ib;
            end
        endcase
        d = r[15:0];
    endfunction

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int ptr, output int g);
        logic [N-1:0] sh, r;
        int idx;
        g = -1;
        r = '0;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            sh  = v >> idx;
            if (g < 0 && sh[0]) g = idx;
        end
        if (g >= 0) r = N'(1) << g;
        return r;
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int g, age;
        exp_t e;
        cyc++;
        if (reset) begin
            sb.delete();
            inflight   = 1'b0;
            model_ptr  = 0;
            prev_reset = 1'b1;
        end else begin
            if (prev_reset) begin
                chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("reset_rsp_data",  32'(rsp_data),  32'd0);
                chk("reset_rsp_id",    32'(rsp_id),    32'd0);
                chk("reset_rsp_err",   32'(rsp_err),   32'd0);
                chk("reset_busy",      32'(busy),      32'd0);
                chk("reset_alu_bus",   {14'd0, alu_op, alu_a, alu_b}, 32'd0);
                prev_reset = 1'b0;
            end
            if (!inflight) begin
                exp_rdy = rr_pick(req_valid, model_ptr, g);
                chk("req_ready_idle", 32'(req_ready), 32'(exp_rdy));
                chk("busy_idle",      32'(busy),      32'd0);
                chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                if (g >= 0) begin
                    e.id = g;
                    e.a  = ta[IW'(g)];
                    e.b  = tbv[IW'(g)];
                    e.op = top_[IW'(g)];
                    ref_op(e.a, e.b, e.op, e.data, e.err);
                    if (e.err) begin e.a = 8'd0; e.b = 8'd0; e.op = 2'b00; end
                    sb.push_back(e);
                    inflight  = 1'b1;
                    acc_cyc   = cyc;
                    model_ptr = (g + 1) % N;
                    $display("accept id=%0d a=%0d b=%0d op=%0d cycle=%0d", g, ta[IW'(g)], tbv[IW'(g)], top_[IW'(g)], cyc);
                end
            end else begin
                e   = sb[0];
                age = cyc - acc_cyc;
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                chk("busy_active",    32'(busy),      32'd1);
                if (age <= ALU_LAT + 1) begin
                    chk("rsp_valid_exec", 32'(rsp_valid), 32'd0);
                    chk("alu_a_exec",     32'(alu_a),     32'(e.a));
                    chk("alu_b_exec",     32'(alu_b),     32'(e.b));
                    chk("alu_op_exec",    32'(alu_op),    32'(e.op));
                end else begin
                    chk("rsp_valid_resp", 32'(rsp_valid), 32'd1);
                    if (rsp_valid) begin
                        chk("rsp_data", 32'(rsp_data), 32'(e.data));
                        chk("rsp_id",   32'(rsp_id),   32'(e.id));
                        chk("rsp_err",  32'(rsp_err),  32'(e.err));
                        if (rsp_ready) begin
                            $display("response id=%0d data=%h err=%0d cycle=%0d", rsp_id, rsp_data, rsp_err, cyc);
                            void'(sb.pop_front());
                            inflight = 1'b0;
                        end
                    end else begin
                        void'(sb.pop_front());
                        inflight = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        ta[IW'(i)]   = a;
        tbv[IW'(i)]  = b;
        top_[IW'(i)] = op;
        req_valid    = req_valid | (N'(1) << i);
    endtask

    task automatic clr_req(input int i);
        req_valid = req_valid & ~(N'(1) << i);
    endtask

    task automatic wait_grant(input int i);
        logic [N-1:0] sh;
        bit got;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            sh  = (req_valid & req_ready) >> i;
            got = sh[0] && !reset;
            step();
            if (got) begin
                clr_req(i);
                return;
            end
        end
        timeout("grant");
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 60; t++) begin
            step();
            if (!inflight) return;
        end
        timeout("idle");
    endtask

    initial begin
        logic [N-1:0] acc, sh;
        int grants;
        bit ok;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            ta[IW'(i)] = '0; tbv[IW'(i)] = '0; top_[IW'(i)] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // All requesters hold mul i*10 x 3: grant order 0,1,2,3,0.
        for (int i = 0; i < N; i++) set_req(i, 8'(i * 10), 8'd3, 2'b10);
        grants = 0;
        for (int t = 0; t < 80 && grants < 5; t++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            step();
            if (acc != '0) grants++;
        end
        if (grants < 5) timeout("round_robin");
        req_valid = '0;
        wait_idle();

        // Single add on requester 0.
        set_req(0, 8'd100, 8'd200, 2'b00);
        wait_grant(0);
        wait_idle();

        // Requester 2: sub, mul, div.
        set_req(2, 8'd3, 8'd5, 2'b01);     wait_grant(2); wait_idle();
        set_req(2, 8'd255, 8'd255, 2'b10); wait_grant(2); wait_idle();
        set_req(2, 8'd200, 8'd7, 2'b11);   wait_grant(2); wait_idle();

        // Divide by zero on requester 1.
        set_req(1, 8'd9, 8'd0, 2'b11);
        wait_grant(1);
        wait_idle();

        // Response backpressure with requester 3 waiting.
        rsp_ready = 1'b0;
        set_req(2, 8'd50, 8'd60, 2'b00);
        wait_grant(2);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            step();
            ok = rsp_valid;
        end
        if (!ok) timeout("backpressure_valid");
        set_req(3, 8'd7, 8'd8, 2'b01);
        repeat (5) step();
        rsp_ready = 1'b1;
        wait_grant(3);
        wait_idle();

        // Reset during EXEC of requester 1, then 0 and 1 together.
        set_req(1, 8'd11, 8'd22, 2'b10);
        wait_grant(1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        set_req(0, 8'd1, 8'd2, 2'b00);
        set_req(1, 8'd3, 8'd4, 2'b00);
        wait_grant(0); wait_idle();
        wait_grant(1); wait_idle();

        // Random traffic with drops, backpressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = reset ? '0 : (req_valid & req_ready);
            step();
            reset     = ($urandom_range(0, 399) == 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) begin
                sh = acc >> i;
                if (sh[0]) clr_req(i);
                sh = req_valid >> i;
                if (!sh[0] && $urandom_range(0, 3) == 0)
                    set_req(i, 8'($urandom), ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom), 2'($urandom));
                else if (sh[0] && !acc[IW'(i)] && $urandom_range(0, 19) == 0)
                    clr_req(i);
            end
        end
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected completion within 1 ms");
        n_total++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
